// File: rtl/seq_accumulator_pkg.sv
// rtl/seq_accumulator_pkg.sv - shared types and constants for the burst accumulator
package seq_accumulator_pkg;

  localparam int DATA_W        = 32;
  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/carry_select_adder.sv
// rtl/carry_select_adder.sv - 32-bit carry-select adder with carry-out and signed overflow
module carry_select_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        overflow
);

  localparam int BLK  = 4;
  localparam int NBLK = 8;

  logic [NBLK:0] carry;

  assign carry[0] = cin;

  // Each nibble precomputes both carry-in outcomes; the incoming carry only selects.
  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [BLK:0] r0;
    logic [BLK:0] r1;
    assign r0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
    assign r1 = r0 + (BLK+1)'(1);
    assign sum[g*BLK +: BLK] = carry[g] ? r1[BLK-1:0] : r0[BLK-1:0];
    assign carry[g+1]        = carry[g] ? r1[BLK]     : r0[BLK];
  end

  assign cout     = carry[NBLK];
  assign overflow = (a[31] == b[31]) && (sum[31] != a[31]);

endmodule

// File: rtl/seq_accumulator.sv
// rtl/seq_accumulator.sv - signed add/subtract burst accumulator with held result handshake
module seq_accumulator
  import seq_accumulator_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_sub,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_sum,
  output logic              out_cout,
  output logic              out_overflow,
  output logic [CNT_W-1:0]  out_count
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic [DATA_W-1:0]  add_a, add_b, add_sum;
  logic               add_cin, add_cout, add_ovf;

  assign accept  = in_valid && in_ready_q;
  // The first beat of a burst starts from zero regardless of what acc holds.
  assign add_a   = (state_q == ST_IDLE) ? '0 : acc_q;
  assign add_b   = in_sub ? ~in_data : in_data;
  assign add_cin = in_sub;

  carry_select_adder u_adder (
    .a        (add_a),
    .b        (add_b),
    .cin      (add_cin),
    .sum      (add_sum),
    .cout     (add_cout),
    .overflow (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d   = add_sum;
          cout_d  = add_cout;
          ovf_d   = add_ovf;
          count_d = CNT_W'(1);
          state_d = in_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d   = add_sum;
          cout_d  = add_cout;
          ovf_d   = ovf_q | add_ovf;
          count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
          state_d = in_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          count_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d != ST_HOLD);
    out_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_sum      = acc_q;
  assign out_cout     = cout_q;
  assign out_overflow = ovf_q;
  assign out_count    = count_q;

endmodule

// File: tb/tb_seq_accumulator.sv
// tb/tb_seq_accumulator.sv - directed and randomized self-checking bench for seq_accumulator
module tb_seq_accumulator;

  localparam int CNT_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              in_sub;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_sum;
  logic              out_cout;
  logic              out_overflow;
  logic [CNT_W-1:0]  out_count;

  always #5 clk = ~clk;

  seq_accumulator #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_sub       (in_sub),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_cout     (out_cout),
    .out_overflow (out_overflow),
    .out_count    (out_count)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] m_acc;
  logic        m_cout;
  logic        m_ovf;
  int          m_cnt;
  bit          m_fresh;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = '0; m_cout = 1'b0; m_ovf = 1'b0; m_cnt = 0; m_fresh = 1'b1;
  endtask

  // Reference: exact unsigned and signed sums in 64 bits, then reduce.
  task automatic model_beat(input logic [31:0] d, input logic s);
    logic [31:0]        a, b;
    logic [63:0]        u;
    logic signed [63:0] sv;
    logic               new_ovf;
    a  = m_fresh ? 32'h0 : m_acc;
    b  = s ? ~d : d;
    u  = {32'h0, a} + {32'h0, b} + {63'h0, s};
    sv = 64'($signed(a)) + 64'($signed(b)) + {63'h0, s};
    new_ovf = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    m_acc  = u[31:0];
    m_cout = u[32];
    m_ovf  = m_fresh ? new_ovf : (m_ovf | new_ovf);
    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    m_fresh = 1'b0;
  endtask

  task automatic chk_outputs(input string tag, input logic exp_hold);
    chk({tag, "_sum"},   out_sum, m_acc);
    chk({tag, "_cout"},  {31'h0, out_cout}, {31'h0, m_cout});
    chk({tag, "_ovf"},   {31'h0, out_overflow}, {31'h0, m_ovf});
    chk({tag, "_count"}, {24'h0, out_count}, m_cnt);
    chk({tag, "_valid"}, {31'h0, out_valid}, {31'h0, exp_hold});
    chk({tag, "_ready"}, {31'h0, in_ready}, {31'h0, ~exp_hold});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sum"},   out_sum, 32'h0);
    chk({tag, "_cout"},  {31'h0, out_cout}, 32'h0);
    chk({tag, "_ovf"},   {31'h0, out_overflow}, 32'h0);
    chk({tag, "_count"}, {24'h0, out_count}, 32'h0);
    chk({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
    chk({tag, "_ready"}, {31'h0, in_ready}, 32'h0);
  endtask

  task automatic beat(input logic [31:0] d, input logic s, input logic l);
    in_valid = 1'b1; in_data = d; in_sub = s; in_last = l;
    chk("ready_before_beat", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_sub = 1'b0; in_data = $urandom;
    model_beat(d, s);
    chk_outputs(l ? "hold" : "accum", l);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    model_reset();
    chk_outputs("after_handshake", 1'b0);
  endtask

  function automatic logic [31:0] pick_data();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] d;
    int          len;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sub = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    rst_n = 1'b1;
    #1 chk("ready_before_first_edge", {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    chk("ready_after_first_edge", {31'h0, in_ready}, 32'h1);

    beat(32'd5, 1'b0, 1'b0);
    beat(32'd7, 1'b0, 1'b0);
    beat(32'd10, 1'b0, 1'b1);
    chk("basic_sum", out_sum, 32'd22);
    chk("basic_ovf", {31'h0, out_overflow}, 32'h0);
    chk("basic_count", {24'h0, out_count}, 32'd3);
    take_result();

    // out_ready held high outside HOLD must not disturb the burst.
    out_ready = 1'b1;
    beat(32'd3, 1'b0, 1'b0);
    beat(32'd5, 1'b1, 1'b1);
    chk("sub_sum", out_sum, 32'hFFFF_FFFE);
    chk("sub_cout", {31'h0, out_cout}, 32'h0);
    chk("sub_ovf", {31'h0, out_overflow}, 32'h0);
    @(negedge clk);
    out_ready = 1'b0;
    model_reset();
    chk_outputs("auto_handshake", 1'b0);

    beat(32'h7FFF_FFFF, 1'b0, 1'b0);
    beat(32'd1, 1'b0, 1'b0);
    beat(32'd1, 1'b1, 1'b1);
    chk("sticky_sum", out_sum, 32'h7FFF_FFFF);
    chk("sticky_ovf", {31'h0, out_overflow}, 32'h1);
    take_result();

    beat($urandom, 1'b0, 1'b0);
    beat($urandom, 1'b1, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = $urandom; in_sub = 1'($urandom); in_last = 1'($urandom);
      @(negedge clk);
      chk_outputs("hold_wait", 1'b1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    take_result();
    d = $urandom;
    beat(d, 1'b0, 1'b1);
    chk("fresh_start", out_sum, d);
    take_result();

    for (int i = 0; i < 300; i++) beat($urandom, 1'b0, (i == 299));
    chk("count_saturated", {24'h0, out_count}, 32'd255);
    take_result();

    for (int n = 0; n < 25; n++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) beat(pick_data(), 1'($urandom), (i == len - 1));
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk_outputs("rand_hold", 1'b1);
      end
      take_result();
    end

    beat($urandom, 1'b0, 1'b0);
    beat($urandom, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_mid_burst");
    @(negedge clk);
    chk_reset_vals("rst_mid_held");
    rst_n = 1'b1;
    model_reset();
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_valid_after_mid_rst", {31'h0, out_valid}, 32'h0);
    end
    out_ready = 1'b0;

    beat($urandom, 1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("rst_in_hold");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_valid_after_hold_rst", {31'h0, out_valid}, 32'h0);
    end
    out_ready = 1'b0;
    chk_outputs("idle_after_rst", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
